clic_irq_arbiter: RTL and testbench
===================================

Name: clic_irq_arbiter

Overview:
- Sequential arbiter between the CLIC register adapter outputs and the hart's interrupt interface.
- Each cycle it selects the highest-priority pending, enabled source above the mode threshold.
- Offers the selected source to the core with a valid/ready handshake, revokes the offer via a kill handshake when the selection becomes stale, and pulses a claim for edge-triggered sources.
- After each claim it enforces a holdoff window so the pending-bit clear can propagate through the register file.

Parameters:
- N_SOURCE, 32: number of interrupt sources; minimum 2.
- SRC_W, $clog2(N_SOURCE): width of a source id (derived).
- HOLDOFF_CYCLES, 2: idle cycles after a claim before the next offer; range 0..15.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- ip_i  in  N_SOURCE  pending bits (from gateway/regfile)
- ie_i  in  N_SOURCE  enable bits
- le_i  in  N_SOURCE  1 = edge-triggered
- shv_i  in  N_SOURCE  selective hardware vectoring
- intctl_i  in  8 x [N_SOURCE]  per-source level/priority
- thresh_i  in  8  current mode interrupt threshold
- irq_valid_o  out  1  offer valid
- irq_ready_i  in  1  core accepts the offer
- irq_id_o  out  SRC_W  offered source id
- irq_level_o  out  8  offered intctl
- irq_shv_o  out  1  offered shv
- irq_kill_req_o  out  1  request to withdraw the offer
- irq_kill_ack_i  in  1  core confirms withdrawal
- claim_o  out  1  one-cycle pulse on accept of an edge-triggered source
- claim_id_o  out  SRC_W  id to clear; valid while claim_o is high

Behaviour:
- Eligibility: ip_i[i] & ie_i[i] & (intctl_i[i] > thresh_i), unsigned 8-bit compare.
- Winner: the maximum intctl among eligible sources; ties go to the higher id.
- Selection stage: a comb reduction tree, registered. The registered winner is {win_vld, win_id, win_lvl, win_shv, win_le}, giving 1-cycle latency from input change to win_* update.
- FSM states: IDLE, OFFER, KILL, HOLD.
  - IDLE: if win_vld, capture win_* into the offer register and go to OFFER. irq_valid_o rises the same cycle as the transition is registered, i.e. 2 cycles after eligibility.
  - OFFER: irq_valid_o=1. irq_id_o, irq_level_o and irq_shv_o stay stable until the state is left.
    - valid & ready: claim_o=le of the offer and claim_id_o=offered id, both for exactly one cycle (next cycle, registered). Go to HOLD.
    - Otherwise, if the offered source is no longer eligible in win_* terms, or win_lvl > offered level (strict), go to KILL.
  - KILL: irq_valid_o=1, irq_kill_req_o=1.
    - irq_ready_i=1 has priority over kill_ack: treat as accept (claim as above), go to HOLD, drop kill_req.
    - Else irq_kill_ack_i=1: drop valid and kill_req next cycle, go to IDLE. No claim is issued.
  - HOLD: irq_valid_o=0. A 4-bit down-counter is loaded with HOLDOFF_CYCLES on entry. Go to IDLE when it reads 0; HOLDOFF_CYCLES=0 means a single HOLD cycle.
- A win_* change to a higher id at equal level does not trigger a kill; only strictly higher level or ineligibility does.
- The level-sensitive source stays pending after accept; it is re-offered after HOLD if still eligible. No claim_o is issued for level-sensitive sources.
- Reset (async, any state): FSM=IDLE, counter=0, win_vld=0. All outputs 0: irq_valid_o, irq_kill_req_o, claim_o, irq_id_o, irq_level_o, irq_shv_o, claim_id_o. The offer is lost with no claim.
- irq_ready_i and irq_kill_ack_i are ignored in IDLE and HOLD. irq_ready_i alone is ignored in KILL only once the state has left.

Decomposition:
- Package clic_arb_pkg:
  - typedef winner_t {vld, id, lvl, shv, le}, parameterised through SRC_W via a localparam struct in the module.
  - enum arb_state_e {IDLE, OFFER, KILL, HOLD}.
- Sub-module clic_max_tree: combinational level/id maximum tree with higher-id tie-break. It is reused by future per-VS arbitration.

Test Plan:
- Single source: id5, lvl 0x80, le=1, thresh 0; ready on the 1st valid cycle → valid at cycle 2, id=5, level=0x80; claim_o one cycle with claim_id=5; no valid during 2 HOLD cycles.
- Tie and priority: ids 3 and 9 both at 0x40, id 12 at 0x60 → offer id12. With id12 removed and the 0x40 pair remaining → offer id9.
- Preemption: offering id2 at 0x20 without ready; id7 at 0xA0 arrives → kill_req at +2 cycles. kill_ack → valid drops, no claim; id7 offered afterwards.
- Simultaneous ready and kill_ack in KILL → accept wins: claim for the offered id, then HOLD.
- Threshold: source at 0x30 with thresh 0x30 → never offered; raising the source level to 0x31 → offered.
- Reset asserted in OFFER and in HOLD → all outputs 0 immediately (asynchronously). After deassert with the source still pending, it is re-offered 2 cycles later.

Source files
------------

// File: rtl/clic_arb_pkg.sv
// Shared types and helpers for the CLIC interrupt arbiter and its max tree.
package clic_arb_pkg;

   localparam int LVL_W = 8;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      OFFER,
      KILL,
      HOLD
   } arb_state_e;

   // b sits on the higher-id side of every tree node, so equal levels resolve to b.
   function automatic logic beats(input logic b_vld, input logic a_vld,
                                  input logic [LVL_W-1:0] b_lvl,
                                  input logic [LVL_W-1:0] a_lvl);
      return b_vld && (!a_vld || (b_lvl >= a_lvl));
   endfunction

endpackage

// File: rtl/clic_max_tree.sv
// Combinational maximum-level tree over N candidates; ties resolve to the higher id.
module clic_max_tree
   import clic_arb_pkg::*;
#(
   parameter int N    = 32,
   parameter int ID_W = $clog2(N)
) (
   input  logic [N-1:0]            i_vld,
   input  logic [N-1:0][LVL_W-1:0] i_lvl,
   output logic                    o_vld,
   output logic [ID_W-1:0]         o_id,
   output logic [LVL_W-1:0]        o_lvl
);

   localparam int NP = 1 << $clog2(N);
   localparam int NN = 2 * NP - 1;

   // Heap layout: node k has children 2k+1 (lower ids) and 2k+2 (higher ids).
   always_comb begin : p_tree
      logic [NN-1:0]            n_vld;
      logic [NN-1:0][ID_W-1:0]  n_id;
      logic [NN-1:0][LVL_W-1:0] n_lvl;
      n_vld = '0;
      n_id  = '0;
      n_lvl = '0;
      for (int k = 0; k < N; k++) begin
         n_vld[NP-1+k] = i_vld[k];
         n_id[NP-1+k]  = ID_W'(k);
         n_lvl[NP-1+k] = i_vld[k] ? i_lvl[k] : '0;
      end
      for (int k = NP - 2; k >= 0; k--) begin
         if (beats(n_vld[2*k+2], n_vld[2*k+1], n_lvl[2*k+2], n_lvl[2*k+1])) begin
            n_id[k]  = n_id[2*k+2];
            n_lvl[k] = n_lvl[2*k+2];
         end else begin
            n_id[k]  = n_id[2*k+1];
            n_lvl[k] = n_lvl[2*k+1];
         end
         n_vld[k] = n_vld[2*k+1] | n_vld[2*k+2];
      end
      o_vld = n_vld[0];
      o_id  = n_id[0];
      o_lvl = n_lvl[0];
   end

endmodule

// File: rtl/clic_irq_arbiter.sv
// Selects the highest-priority eligible CLIC source and offers it to the hart,
// with kill on stale selection, claim pulses for edge sources and a post-claim holdoff.
module clic_irq_arbiter
   import clic_arb_pkg::*;
#(
   parameter int N_SOURCE       = 32,
   parameter int SRC_W          = $clog2(N_SOURCE),
   parameter int HOLDOFF_CYCLES = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [N_SOURCE-1:0]            ip_i,
   input  logic [N_SOURCE-1:0]            ie_i,
   input  logic [N_SOURCE-1:0]            le_i,
   input  logic [N_SOURCE-1:0]            shv_i,
   input  logic [N_SOURCE-1:0][LVL_W-1:0] intctl_i,
   input  logic [LVL_W-1:0]               thresh_i,
   output logic                           irq_valid_o,
   input  logic                           irq_ready_i,
   output logic [SRC_W-1:0]               irq_id_o,
   output logic [LVL_W-1:0]               irq_level_o,
   output logic                           irq_shv_o,
   output logic                           irq_kill_req_o,
   input  logic                           irq_kill_ack_i,
   output logic                           claim_o,
   output logic [SRC_W-1:0]               claim_id_o
);

   typedef struct packed {
      logic             vld;
      logic [SRC_W-1:0] id;
      logic [LVL_W-1:0] lvl;
      logic             shv;
      logic             le;
   } winner_t;

   logic [N_SOURCE-1:0] w_elig;
   logic                w_tree_vld;
   logic [SRC_W-1:0]    w_tree_id;
   logic [LVL_W-1:0]    w_tree_lvl;
   winner_t             w_win;
   logic                w_stale;

   winner_t             r_win;
   logic [N_SOURCE-1:0] r_elig;
   arb_state_e          r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_valid;
   logic                r_kill;
   logic                r_claim;
   logic [SRC_W-1:0]    r_claim_id;
   logic [SRC_W-1:0]    r_offer_id;
   logic [LVL_W-1:0]    r_offer_lvl;
   logic                r_offer_shv;
   logic                r_offer_le;

   generate
      for (genvar gi = 0; gi < N_SOURCE; gi++) begin : g_elig
         assign w_elig[gi] = ip_i[gi] & ie_i[gi] & (intctl_i[gi] > thresh_i);
      end
   endgenerate

   clic_max_tree #(
      .N    (N_SOURCE),
      .ID_W (SRC_W)
   ) u_max_tree (
      .i_vld (w_elig),
      .i_lvl (intctl_i),
      .o_vld (w_tree_vld),
      .o_id  (w_tree_id),
      .o_lvl (w_tree_lvl)
   );

   assign w_win = '{vld: w_tree_vld, id: w_tree_id, lvl: w_tree_lvl,
                    shv: shv_i[w_tree_id], le: le_i[w_tree_id]};

   // Same-level winner changes never preempt; only loss of eligibility or a strictly higher level.
   assign w_stale = !r_elig[r_offer_id] || (r_win.vld && (r_win.lvl > r_offer_lvl));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_win       <= '0;
         r_elig      <= '0;
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_valid     <= 1'b0;
         r_kill      <= 1'b0;
         r_claim     <= 1'b0;
         r_claim_id  <= '0;
         r_offer_id  <= '0;
         r_offer_lvl <= '0;
         r_offer_shv <= 1'b0;
         r_offer_le  <= 1'b0;
      end else begin
         r_win   <= w_win;
         r_elig  <= w_elig;
         r_claim <= 1'b0;
         case (r_state)
            IDLE: begin
               if (r_win.vld) begin
                  r_offer_id  <= r_win.id;
                  r_offer_lvl <= r_win.lvl;
                  r_offer_shv <= r_win.shv;
                  r_offer_le  <= r_win.le;
                  r_valid     <= 1'b1;
                  r_state     <= OFFER;
               end
            end
            OFFER, KILL: begin
               if (irq_ready_i) begin
                  r_valid    <= 1'b0;
                  r_kill     <= 1'b0;
                  r_claim    <= r_offer_le;
                  r_claim_id <= r_offer_id;
                  r_cnt      <= CNT_W'(HOLDOFF_CYCLES);
                  r_state    <= HOLD;
               end else if (r_state == KILL) begin
                  if (irq_kill_ack_i) begin
                     r_valid <= 1'b0;
                     r_kill  <= 1'b0;
                     r_state <= IDLE;
                  end
               end else if (w_stale) begin
                  r_kill  <= 1'b1;
                  r_state <= KILL;
               end
            end
            HOLD: begin
               if (r_cnt == '0) begin
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign irq_valid_o    = r_valid;
   assign irq_kill_req_o = r_kill;
   assign irq_id_o       = r_offer_id;
   assign irq_level_o    = r_offer_lvl;
   assign irq_shv_o      = r_offer_shv;
   assign claim_o        = r_claim;
   assign claim_id_o     = r_claim_id;

endmodule

// File: tb/tb_clic_irq_arbiter.sv
// Directed bench for clic_irq_arbiter: offer latency, priority, kill, claim, holdoff and reset.
module tb_clic_irq_arbiter;

   localparam int N  = 32;
   localparam int SW = 5;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N-1:0]      ip, ie, le, shv;
   logic [N-1:0][7:0] intctl;
   logic [7:0]        thresh;
   logic              irq_ready, irq_kill_ack;
   logic              irq_valid, irq_shv, irq_kill_req, claim;
   logic [SW-1:0]     irq_id, claim_id;
   logic [7:0]        irq_level;

   int checks   = 0;
   int failures = 0;

   clic_irq_arbiter #(
      .N_SOURCE       (N),
      .HOLDOFF_CYCLES (2)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .ip_i           (ip),
      .ie_i           (ie),
      .le_i           (le),
      .shv_i          (shv),
      .intctl_i       (intctl),
      .thresh_i       (thresh),
      .irq_valid_o    (irq_valid),
      .irq_ready_i    (irq_ready),
      .irq_id_o       (irq_id),
      .irq_level_o    (irq_level),
      .irq_shv_o      (irq_shv),
      .irq_kill_req_o (irq_kill_req),
      .irq_kill_ack_i (irq_kill_ack),
      .claim_o        (claim),
      .claim_id_o     (claim_id)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ip = '0; ie = '0; le = '0; shv = '0; intctl = '0; thresh = '0;
      irq_ready = 1'b0; irq_kill_ack = 1'b0;
   endtask

   task automatic add_src(input int id, input logic [7:0] lvl, input logic edge_trig);
      ip[id] = 1'b1; ie[id] = 1'b1; le[id] = edge_trig; intctl[id] = lvl;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      checks++;
      if ({irq_valid, irq_kill_req, claim, irq_shv} !== 4'b0) begin
         $display("FAIL reset_flags: got %b expected 0000", {irq_valid, irq_kill_req, claim, irq_shv});
         failures++;
      end
      checks++;
      if ({irq_id, irq_level, claim_id} !== '0) begin
         $display("FAIL reset_data: got id=%0d lvl=%h cid=%0d expected 0", irq_id, irq_level, claim_id);
         failures++;
      end
      rst = 1'b0;
      tick();
      $display("test_reset done");
   endtask

   task automatic test_single();
      do_reset();
      add_src(5, 8'h80, 1'b1);
      tick();
      checks++;
      if (irq_valid !== 1'b0) begin
         $display("FAIL single_early: valid got %b expected 0", irq_valid); failures++;
      end
      tick();
      checks++;
      if (irq_valid !== 1'b1 || irq_id !== 5'd5 || irq_level !== 8'h80) begin
         $display("FAIL single_offer: got v=%b id=%0d lvl=%h expected v=1 id=5 lvl=80", irq_valid, irq_id, irq_level);
         failures++;
      end
      irq_ready = 1'b1;
      tick();
      irq_ready = 1'b0;
      ip[5] = 1'b0;
      checks++;
      if (claim !== 1'b1 || claim_id !== 5'd5 || irq_valid !== 1'b0) begin
         $display("FAIL single_claim: got c=%b cid=%0d v=%b expected c=1 cid=5 v=0", claim, claim_id, irq_valid);
         failures++;
      end
      tick();
      checks++;
      if (claim !== 1'b0 || irq_valid !== 1'b0) begin
         $display("FAIL single_hold1: got c=%b v=%b expected 0 0", claim, irq_valid); failures++;
      end
      tick();
      checks++;
      if (irq_valid !== 1'b0) begin
         $display("FAIL single_hold2: valid got %b expected 0", irq_valid); failures++;
      end
      $display("test_single done");
   endtask

   task automatic test_level();
      do_reset();
      add_src(10, 8'h70, 1'b0);
      tick(); tick();
      irq_ready = 1'b1;
      tick();
      irq_ready = 1'b0;
      checks++;
      if (claim !== 1'b0 || irq_valid !== 1'b0) begin
         $display("FAIL level_noclaim: got c=%b v=%b expected 0 0", claim, irq_valid); failures++;
      end
      tick(); tick(); tick();
      checks++;
      if (irq_valid !== 1'b0) begin
         $display("FAIL level_idle: valid got %b expected 0", irq_valid); failures++;
      end
      tick();
      checks++;
      if (irq_valid !== 1'b1 || irq_id !== 5'd10) begin
         $display("FAIL level_reoffer: got v=%b id=%0d expected v=1 id=10", irq_valid, irq_id); failures++;
      end
      $display("test_level done");
   endtask

   task automatic test_priority();
      do_reset();
      add_src(3, 8'h40, 1'b0);
      add_src(9, 8'h40, 1'b0);
      add_src(12, 8'h60, 1'b0);
      tick(); tick();
      checks++;
      if (irq_valid !== 1'b1 || irq_id !== 5'd12 || irq_level !== 8'h60) begin
         $display("FAIL prio_max: got v=%b id=%0d lvl=%h expected v=1 id=12 lvl=60", irq_valid, irq_id, irq_level);
         failures++;
      end
      ip[12] = 1'b0;
      tick(); tick();
      checks++;
      if (irq_kill_req !== 1'b1 || irq_valid !== 1'b1) begin
         $display("FAIL prio_kill: got k=%b v=%b expected 1 1", irq_kill_req, irq_valid); failures++;
      end
      irq_kill_ack = 1'b1;
      tick();
      irq_kill_ack = 1'b0;
      tick();
      checks++;
      if (irq_valid !== 1'b1 || irq_id !== 5'd9 || irq_level !== 8'h40) begin
         $display("FAIL prio_tie: got v=%b id=%0d lvl=%h expected v=1 id=9 lvl=40", irq_valid, irq_id, irq_level);
         failures++;
      end
      $display("test_priority done");
   endtask

   task automatic test_preempt();
      do_reset();
      add_src(2, 8'h20, 1'b1);
      tick(); tick();
      add_src(7, 8'hA0, 1'b1);
      tick();
      checks++;
      if (irq_kill_req !== 1'b0) begin
         $display("FAIL preempt_early: kill got %b expected 0", irq_kill_req); failures++;
      end
      tick();
      checks++;
      if (irq_kill_req !== 1'b1 || irq_valid !== 1'b1 || irq_id !== 5'd2) begin
         $display("FAIL preempt_kill: got k=%b v=%b id=%0d expected 1 1 2", irq_kill_req, irq_valid, irq_id);
         failures++;
      end
      irq_kill_ack = 1'b1;
      tick();
      irq_kill_ack = 1'b0;
      checks++;
      if (irq_valid !== 1'b0 || irq_kill_req !== 1'b0 || claim !== 1'b0) begin
         $display("FAIL preempt_drop: got v=%b k=%b c=%b expected 0 0 0", irq_valid, irq_kill_req, claim);
         failures++;
      end
      tick();
      checks++;
      if (irq_valid !== 1'b1 || irq_id !== 5'd7 || irq_level !== 8'hA0) begin
         $display("FAIL preempt_new: got v=%b id=%0d lvl=%h expected v=1 id=7 lvl=a0", irq_valid, irq_id, irq_level);
         failures++;
      end
      $display("test_preempt done");
   endtask

   task automatic test_ready_and_ack();
      do_reset();
      add_src(2, 8'h20, 1'b1);
      tick(); tick();
      add_src(7, 8'hA0, 1'b1);
      tick(); tick();
      irq_ready = 1'b1;
      irq_kill_ack = 1'b1;
      tick();
      irq_ready = 1'b0;
      irq_kill_ack = 1'b0;
      checks++;
      if (claim !== 1'b1 || claim_id !== 5'd2 || irq_valid !== 1'b0 || irq_kill_req !== 1'b0) begin
         $display("FAIL both_accept: got c=%b cid=%0d v=%b k=%b expected 1 2 0 0", claim, claim_id, irq_valid, irq_kill_req);
         failures++;
      end
      tick();
      checks++;
      if (irq_valid !== 1'b0 || claim !== 1'b0) begin
         $display("FAIL both_hold: got v=%b c=%b expected 0 0", irq_valid, claim); failures++;
      end
      $display("test_ready_and_ack done");
   endtask

   task automatic test_threshold();
      do_reset();
      add_src(4, 8'h30, 1'b0);
      thresh = 8'h30;
      tick(); tick(); tick(); tick();
      checks++;
      if (irq_valid !== 1'b0) begin
         $display("FAIL thresh_equal: valid got %b expected 0", irq_valid); failures++;
      end
      intctl[4] = 8'h31;
      tick(); tick();
      checks++;
      if (irq_valid !== 1'b1 || irq_id !== 5'd4 || irq_level !== 8'h31) begin
         $display("FAIL thresh_above: got v=%b id=%0d lvl=%h expected v=1 id=4 lvl=31", irq_valid, irq_id, irq_level);
         failures++;
      end
      $display("test_threshold done");
   endtask

   task automatic test_async_reset();
      do_reset();
      add_src(6, 8'h50, 1'b1);
      shv[6] = 1'b1;
      tick(); tick();
      checks++;
      if (irq_valid !== 1'b1 || irq_shv !== 1'b1 || irq_id !== 5'd6) begin
         $display("FAIL arst_pre: got v=%b shv=%b id=%0d expected 1 1 6", irq_valid, irq_shv, irq_id); failures++;
      end
      rst = 1'b1;
      #2;
      checks++;
      if ({irq_valid, irq_shv, irq_kill_req, claim} !== 4'b0 || irq_id !== '0 || irq_level !== '0) begin
         $display("FAIL arst_offer: got v=%b shv=%b id=%0d lvl=%h expected all 0", irq_valid, irq_shv, irq_id, irq_level);
         failures++;
      end
      rst = 1'b0;
      tick();
      checks++;
      if (irq_valid !== 1'b0) begin
         $display("FAIL arst_early: valid got %b expected 0", irq_valid); failures++;
      end
      tick();
      checks++;
      if (irq_valid !== 1'b1 || irq_id !== 5'd6) begin
         $display("FAIL arst_reoffer: got v=%b id=%0d expected 1 6", irq_valid, irq_id); failures++;
      end
      irq_ready = 1'b1;
      tick();
      irq_ready = 1'b0;
      checks++;
      if (claim !== 1'b1 || claim_id !== 5'd6) begin
         $display("FAIL arst_claim: got c=%b cid=%0d expected 1 6", claim, claim_id); failures++;
      end
      rst = 1'b1;
      #2;
      checks++;
      if (claim !== 1'b0 || claim_id !== '0 || irq_valid !== 1'b0 || irq_id !== '0) begin
         $display("FAIL arst_hold: got c=%b cid=%0d v=%b id=%0d expected all 0", claim, claim_id, irq_valid, irq_id);
         failures++;
      end
      rst = 1'b0;
      tick(); tick();
      checks++;
      if (irq_valid !== 1'b1 || irq_id !== 5'd6) begin
         $display("FAIL arst_after_hold: got v=%b id=%0d expected 1 6", irq_valid, irq_id); failures++;
      end
      $display("test_async_reset done");
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_single();
      test_level();
      test_priority();
      test_preempt();
      test_ready_and_ack();
      test_threshold();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
